mod_updown_counter: RTL and testbench
=====================================

# mod_updown_counter

Parametrised modulo-N up/down counter, the general successor to the fixed 3-bit down counter. It adds configurable width and modulus, runtime direction, synchronous load, count enable, and a wrap or saturate end mode. It also provides terminal-count and wrap-event outputs. It sits under sequencers and timers anywhere a bounded event or address count is needed.

## Interface
- WIDTH, 3, counter width in bits (1..32)
- MODULUS, 2**WIDTH, count range 0..MODULUS-1; legal range 2..2**WIDTH
- RESET_VAL, MODULUS-1, value loaded by reset; must be < MODULUS
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high; forces the reset values below immediately
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- sat  input  1  end mode: 1 = saturate at bound, 0 = wrap modulo MODULUS
- load  input  1  synchronous load request
- load_val  input  WIDTH  value to load
- q  output  WIDTH  current count, registered
- tc  output  1  terminal count, combinational: q at the bound for the current direction
- wrap  output  1  registered one-cycle pulse marking a wrap
- match_val  input  WIDTH  compare value (present only with COUNTER_MATCH_EN)
- match  output  1  registered compare flag (present only with COUNTER_MATCH_EN)

## Operation
- Reset values: q = RESET_VAL, wrap = 0, match = 0.
- Priority per rising edge: rst, then load, then en, then hold.
- load: q <= load_val when load_val < MODULUS, else q <= MODULUS-1 (clamp).
  - wrap <= 0 on any load cycle.
  - load ignores en, up and sat.
- en with up=1:
  - q < MODULUS-1: q <= q+1.
  - q == MODULUS-1, sat=0: q <= 0 and wrap <= 1.
  - q == MODULUS-1, sat=1: q holds and wrap <= 0.
- en with up=0:
  - q > 0: q <= q-1.
  - q == 0, sat=0: q <= MODULUS-1 and wrap <= 1.
  - q == 0, sat=1: q holds and wrap <= 0.
- en=0 and load=0: q holds and wrap <= 0.
- tc = (up && q == MODULUS-1) || (!up && q == 0). tc is independent of en and sat.
- Arithmetic:
  - Next-value logic uses WIDTH+1 bits internally.
  - q never holds a value ≥ MODULUS. This holds even when MODULUS < 2**WIDTH.
- A direction change mid-count takes effect on the next enabled edge; there is no extra latency.

## Timing
- q updates on the same edge as the qualifying en/load; its latency is 1 cycle from input to q.
- wrap is asserted for exactly the one cycle following the wrapping edge, coincident with the wrapped q value.
- tc follows q and up combinationally, with no register stage.
- Reset asserted mid-count:
  - q and wrap take their reset values asynchronously.
  - On the first rising edge after rst deasserts, normal priority applies.
- Simultaneous load and en: the load wins and no count occurs.
- Inputs must be stable around the rising edge of clk. rst deassertion is assumed synchronised upstream.

## Configuration
- COUNTER_MATCH_EN defined:
  - Adds the match_val input and the match output.
  - On every edge, match <= (next q == match_val). match is therefore high in the same cycle that q equals match_val, including after a load.
  - rst forces match to 0.
- COUNTER_MATCH_EN undefined:
  - match_val and match are absent.
  - No compare logic is generated.

## Structure
- Shared package counter_pkg holds:
  - typedef enum logic {DIR_DOWN = 0, DIR_UP = 1} dir_t;
  - typedef enum logic {END_WRAP = 0, END_SAT = 1} endmode_t;
  - A localparam helper for the clog2-based width check.
- One sub-module, mod_next_val, is combinational. It takes q, up, sat and MODULUS and returns next_q and a wrap_evt flag.
- The top level holds the registers, the load clamp, priority, tc and the optional match register.
- Elaboration checks raise a fatal error when MODULUS > 2**WIDTH, MODULUS < 2 or RESET_VAL ≥ MODULUS.

## Test plan
- Default params (WIDTH=3, MODULUS=8):
  - Drive rst=1, release rst, then en=1, up=0, sat=0 for 9 edges.
  - Required: q is 7 after reset, then 6,5,4,3,2,1,0,7,6.
  - wrap is high only in the cycle where q returns to 7; tc is high when q=0.
- WIDTH=4, MODULUS=10, up=1, sat=0 from q=0 for 11 edges:
  - Required: q runs 1..9, 0, 1.
  - wrap pulses once, coincident with q=0; q never shows 10..15.
- WIDTH=4, MODULUS=10, saturate at both ends:
  - Up with sat=1 from q=8 for 4 edges: q = 9,9,9,9, tc=1, wrap never asserts.
  - Then up=0 from q=1 for 3 edges: q = 0,0,0.
- WIDTH=4, MODULUS=10, load handling:
  - load=1 with load_val=5 and en=1 on the same edge: q=5, no count.
  - load_val=13: q=9 (clamped).
- Async reset mid-count:
  - Assert rst between clock edges while q=3; q becomes RESET_VAL before the next edge.
  - Hold en=1 and release rst: counting resumes from RESET_VAL on the next edge.
- With COUNTER_MATCH_EN, WIDTH=3, MODULUS=8, match_val=2, down count from 7:
  - Required: match is high only while q=2.
  - Load 2: match is high in the cycle after the load edge.

Source files
------------

// File: rtl/mod_updown_counter_pkg.sv
// Shared types and elaboration helpers for the modulo-N up/down counter.
package counter_pkg;

    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;
    typedef enum logic {END_WRAP = 1'b0, END_SAT = 1'b1} endmode_t;

    localparam int unsigned MAX_WIDTH = 32;

    // Bits needed to hold 0..m-1; MODULUS fits WIDTH when this is <= WIDTH.
    function automatic int unsigned mod_bits(longint unsigned m);
        return $clog2(m);
    endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Counter control/status bundle; match_val/match exist only with COUNTER_MATCH_EN.
interface mod_updown_counter_if #(
    parameter int unsigned WIDTH = 3
);
    logic             en;
    logic             up;
    logic             sat;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
`ifdef COUNTER_MATCH_EN
    logic [WIDTH-1:0] match_val;
    logic             match;
`endif

    modport master (
        output en, up, sat, load, load_val,
`ifdef COUNTER_MATCH_EN
        output match_val,
        input  match,
`endif
        input  q, tc, wrap
    );

    modport slave (
        input  en, up, sat, load, load_val,
`ifdef COUNTER_MATCH_EN
        input  match_val,
        output match,
`endif
        output q, tc, wrap
    );

endinterface

// File: rtl/mod_updown_counter_next_val.sv
// Combinational next-count for one enabled step: wraps modulo MODULUS or saturates at the bound.
module mod_next_val
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH   = 3,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic [WIDTH-1:0] q,
    input  dir_t             up,
    input  endmode_t         sat,
    output logic [WIDTH-1:0] next_q,
    output logic             wrap_evt
);

    localparam logic [WIDTH:0] MAX_EXT = (WIDTH + 1)'(MODULUS - 64'd1);

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] sum;
    logic           unused_msb;

    always_comb begin
        q_ext    = {1'b0, q};
        sum      = q_ext;
        wrap_evt = 1'b0;
        if (up == DIR_UP) begin
            if (q_ext == MAX_EXT) begin
                if (sat == END_WRAP) begin
                    sum      = '0;
                    wrap_evt = 1'b1;
                end
            end else begin
                sum = q_ext + 1'b1;
            end
        end else begin
            if (q_ext == '0) begin
                if (sat == END_WRAP) begin
                    sum      = MAX_EXT;
                    wrap_evt = 1'b1;
                end
            end else begin
                sum = q_ext - 1'b1;
            end
        end
        next_q = sum[WIDTH-1:0];
    end

    // The bounds above keep the carry bit clear; it is only headroom.
    assign unused_msb = sum[WIDTH];

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with load clamp, wrap/saturate, tc and wrap pulse.
// Optional registered compare (match_val/match) enabled by COUNTER_MATCH_EN.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH     = 3,
    parameter longint unsigned MODULUS   = 64'd1 << WIDTH,
    parameter longint unsigned RESET_VAL = MODULUS - 64'd1
) (
    input logic                  clk,
    input logic                  rst,
    mod_updown_counter_if.slave  bus
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $fatal(1, "mod_updown_counter: WIDTH must be 1..32");
    end
    if (MODULUS < 2 || mod_bits(MODULUS) > WIDTH) begin : g_bad_modulus
        $fatal(1, "mod_updown_counter: MODULUS must be 2..2**WIDTH");
    end
    if (RESET_VAL >= MODULUS) begin : g_bad_reset
        $fatal(1, "mod_updown_counter: RESET_VAL must be below MODULUS");
    end

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] load_clamped;
    logic             wrap_q, wrap_d;
    logic             wrap_evt;

    mod_next_val #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next_val (
        .q        (q_q),
        .up       (dir_t'(bus.up)),
        .sat      (endmode_t'(bus.sat)),
        .next_q   (step_q),
        .wrap_evt (wrap_evt)
    );

    assign load_clamped = ({1'b0, bus.load_val} < MOD_EXT) ? bus.load_val : MAX_Q;

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            q_d = load_clamped;
        end else if (bus.en) begin
            q_d    = step_q;
            wrap_d = wrap_evt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= RESET_Q;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.wrap = wrap_q;
    assign bus.tc   = bus.up ? (q_q == MAX_Q) : (q_q == '0);

`ifdef COUNTER_MATCH_EN
    logic match_q;

    // Compare against the incoming value so match lines up with q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= (q_d == bus.match_val);
        end
    end

    assign bus.match = match_q;
`endif

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench: a mod-8 (WIDTH=3) and a mod-10 (WIDTH=4) counter share one stimulus set.
module tb_mod_updown_counter;

    logic       clk;
    logic       rst;
    logic       en, up, sat, load;
    logic [3:0] load_val;

    int checks = 0;
    int errors = 0;

    mod_updown_counter_if #(.WIDTH(3)) if8 ();
    mod_updown_counter_if #(.WIDTH(4)) if10 ();

    assign if8.en        = en;
    assign if8.up        = up;
    assign if8.sat       = sat;
    assign if8.load      = load;
    assign if8.load_val  = load_val[2:0];
    assign if10.en       = en;
    assign if10.up       = up;
    assign if10.sat      = sat;
    assign if10.load     = load;
    assign if10.load_val = load_val;
`ifdef COUNTER_MATCH_EN
    assign if8.match_val  = 3'd2;
    assign if10.match_val = 4'd2;
`endif

    mod_updown_counter #(.WIDTH(3)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8.slave)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
        .clk (clk),
        .rst (rst),
        .bus (if10.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en, up, sat, load;
        logic [3:0] lv;
        logic [3:0] q;
        logic       tc, wrap;
    } vec_t;

    localparam int NVEC = 30;
    vec_t vecs[NVEC];

    function automatic vec_t mk(logic e, logic u, logic s, logic l, logic [3:0] lv,
                                logic [3:0] q, logic tc, logic wrap);
        vec_t v;
        v.en = e; v.up = u; v.sat = s; v.load = l; v.lv = lv;
        v.q = q; v.tc = tc; v.wrap = wrap;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic u, input logic s, input logic l,
                         input logic [3:0] lv);
        en = e; up = u; sat = s; load = l; load_val = lv;
    endtask

    int exp8[9] = '{6, 5, 4, 3, 2, 1, 0, 7, 6};

    initial begin
        //                e  u  s  ld lv    q  tc w
        vecs[0]  = mk(1, 1, 0, 1, 4'd0,  0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 0, 4'd0,  1, 0, 0);
        vecs[2]  = mk(1, 1, 0, 0, 4'd0,  2, 0, 0);
        vecs[3]  = mk(1, 1, 0, 0, 4'd0,  3, 0, 0);
        vecs[4]  = mk(1, 1, 0, 0, 4'd0,  4, 0, 0);
        vecs[5]  = mk(1, 1, 0, 0, 4'd0,  5, 0, 0);
        vecs[6]  = mk(1, 1, 0, 0, 4'd0,  6, 0, 0);
        vecs[7]  = mk(1, 1, 0, 0, 4'd0,  7, 0, 0);
        vecs[8]  = mk(1, 1, 0, 0, 4'd0,  8, 0, 0);
        vecs[9]  = mk(1, 1, 0, 0, 4'd0,  9, 1, 0);
        vecs[10] = mk(1, 1, 0, 0, 4'd0,  0, 0, 1);
        vecs[11] = mk(1, 1, 0, 0, 4'd0,  1, 0, 0);
        vecs[12] = mk(0, 1, 1, 1, 4'd8,  8, 0, 0);
        vecs[13] = mk(1, 1, 1, 0, 4'd0,  9, 1, 0);
        vecs[14] = mk(1, 1, 1, 0, 4'd0,  9, 1, 0);
        vecs[15] = mk(1, 1, 1, 0, 4'd0,  9, 1, 0);
        vecs[16] = mk(1, 1, 1, 0, 4'd0,  9, 1, 0);
        vecs[17] = mk(0, 0, 1, 1, 4'd1,  1, 0, 0);
        vecs[18] = mk(1, 0, 1, 0, 4'd0,  0, 1, 0);
        vecs[19] = mk(1, 0, 1, 0, 4'd0,  0, 1, 0);
        vecs[20] = mk(1, 0, 1, 0, 4'd0,  0, 1, 0);
        vecs[21] = mk(1, 1, 0, 1, 4'd5,  5, 0, 0);
        vecs[22] = mk(0, 1, 0, 1, 4'd13, 9, 1, 0);
        vecs[23] = mk(0, 1, 0, 0, 4'd0,  9, 1, 0);
        vecs[24] = mk(0, 0, 0, 1, 4'd0,  0, 1, 0);
        vecs[25] = mk(1, 0, 0, 0, 4'd0,  9, 0, 1);
        vecs[26] = mk(0, 0, 0, 0, 4'd0,  9, 0, 0);
        vecs[27] = mk(1, 0, 0, 0, 4'd0,  8, 0, 0);
        vecs[28] = mk(1, 1, 0, 0, 4'd0,  9, 1, 0);
        vecs[29] = mk(0, 0, 0, 1, 4'd10, 9, 0, 0);

        rst = 1'b1;
        drive(0, 0, 0, 0, 4'd0);
        #3;
        check("rst q8", 32'(if8.q), 32'd7);
        check("rst q10", 32'(if10.q), 32'd9);
        check("rst wrap8", 32'(if8.wrap), 32'd0);
        step();
        step();
        rst = 1'b0;

        // Mod-8 down count through the wrap.
        drive(1, 0, 0, 0, 4'd0);
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("down8[%0d] q", i), 32'(if8.q), 32'(exp8[i]));
            check($sformatf("down8[%0d] wrap", i), 32'(if8.wrap), 32'(exp8[i] == 7));
            check($sformatf("down8[%0d] tc", i), 32'(if8.tc), 32'(exp8[i] == 0));
        end

        // Mod-10 table: wrap, saturate, load priority and clamp, direction changes.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].en, vecs[i].up, vecs[i].sat, vecs[i].load, vecs[i].lv);
            step();
            check($sformatf("vec%0d q", i), 32'(if10.q), 32'(vecs[i].q));
            check($sformatf("vec%0d tc", i), 32'(if10.tc), 32'(vecs[i].tc));
            check($sformatf("vec%0d wrap", i), 32'(if10.wrap), 32'(vecs[i].wrap));
        end

        // Async reset mid-count.
        drive(0, 0, 0, 1, 4'd3);
        step();
        check("pre-rst q10", 32'(if10.q), 32'd3);
        drive(1, 0, 0, 0, 4'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async q10", 32'(if10.q), 32'd9);
        check("async q8", 32'(if8.q), 32'd7);
        check("async wrap10", 32'(if10.wrap), 32'd0);
        step();
        check("held rst q10", 32'(if10.q), 32'd9);
        rst = 1'b0;
        step();
        check("resume q10", 32'(if10.q), 32'd8);
        check("resume q8", 32'(if8.q), 32'd6);

`ifdef COUNTER_MATCH_EN
        drive(0, 0, 0, 1, 4'd7);
        step();
        check("match load7", 32'(if8.match), 32'd0);
        drive(1, 0, 0, 0, 4'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("match down[%0d] q", i), 32'(if8.q), 32'(6 - i + ((i == 7) ? 8 : 0)));
            check($sformatf("match down[%0d]", i), 32'(if8.match), 32'(i == 4));
        end
        drive(0, 0, 0, 1, 4'd2);
        step();
        check("match load2", 32'(if8.match), 32'd1);
        drive(0, 0, 0, 0, 4'd0);
        step();
        check("match hold2", 32'(if8.match), 32'd1);
        rst = 1'b1;
        #1;
        check("match rst", 32'(if8.match), 32'd0);
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
